// File: rtl/seg7_scan_controller.sv
// Four-digit common-anode 7-seg scan scheduler: blanking gap per slot, words swapped only at frame wrap.
// Optional LEADING_ZERO_BLANK_EN: blank leading-zero digits 3..1 during their drive window.
module seg7_scan_controller #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  output logic        frame_tick,
  output logic [0:3]  an,
  output logic [0:6]  seg,
  output logic        dp
);
  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          wrap;
  logic          accept, xfer;
  logic [15:0]   active_word, active_word_nxt, pend_word;
  logic [3:0]    active_dp, active_dp_nxt, pend_dp;
  logic [0:3]    an_nxt;
  logic [0:6]    seg_nxt;
  logic          dp_nxt;

  function automatic logic [0:6] hex7(input logic [3:0] v);
    logic [0:6] r;
    case (v)
      4'h0: r = 7'b0000001;
      4'h1: r = 7'b1001111;
      4'h2: r = 7'b0010010;
      4'h3: r = 7'b0000110;
      4'h4: r = 7'b1001100;
      4'h5: r = 7'b0100100;
      4'h6: r = 7'b0100000;
      4'h7: r = 7'b0001111;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0000100;
      4'hA: r = 7'b0001000;
      4'hB: r = 7'b1100000;
      4'hC: r = 7'b0110001;
      4'hD: r = 7'b1000010;
      4'hE: r = 7'b0110000;
      default: r = 7'b0111000;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    wrap      = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        BLANK: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == BLANK_LAST) state_nxt = DRIVE;
        end
        DRIVE: begin
          if (cnt == SLOT_LAST) begin
            cnt_nxt   = '0;
            idx_nxt   = idx + 1'b1;
            state_nxt = BLANK;
            wrap      = (idx == 2'd3);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Pending word moves to active during the frame_tick cycle or any idle cycle;
  // wr_ready low doubles as the pending-full flag.
  assign accept = wr_valid & wr_ready;
  assign xfer   = ~wr_ready & ((state == IDLE) | frame_tick);

  always_comb begin
    active_word_nxt = active_word;
    active_dp_nxt   = active_dp;
    if (xfer) begin
      active_word_nxt = pend_word;
      active_dp_nxt   = pend_dp;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] lead_zero;
  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (active_word_nxt[15:12] == 4'h0);
    lead_zero[2] = (active_word_nxt[15:8]  == 8'h00);
    lead_zero[1] = (active_word_nxt[15:4]  == 12'h000);
  end
`endif

  // Outputs are decoded from next-cycle values so the registered pins line up with the state.
  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = 7'b1111111;
    dp_nxt  = 1'b1;
    if (state_nxt == DRIVE) begin
      an_nxt[idx_nxt] = 1'b0;
      seg_nxt         = hex7(active_word_nxt[{idx_nxt, 2'b00} +: 4]);
      dp_nxt          = ~active_dp_nxt[idx_nxt];
`ifdef LEADING_ZERO_BLANK_EN
      if (lead_zero[idx_nxt]) seg_nxt = 7'b1111111;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick  <= 1'b0;
      wr_ready    <= 1'b1;
      pend_word   <= '0;
      pend_dp     <= '0;
      active_word <= '0;
      active_dp   <= '0;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
    end else begin
      frame_tick  <= wrap;
      active_word <= active_word_nxt;
      active_dp   <= active_dp_nxt;
      an          <= an_nxt;
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      if (accept) begin
        pend_word <= wr_data;
        pend_dp   <= wr_dp;
        wr_ready  <= 1'b0;
      end else if (xfer) begin
        wr_ready <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller: frame-position reference model, decode vector table, directed corner sequences.
module tb_seg7_scan_controller;
  localparam int DC = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n, enable, wr_valid, wr_ready, frame_tick, dp;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [0:3]  an;
  logic [0:6]  seg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_scan_controller #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_dp(wr_dp), .frame_tick(frame_tick), .an(an), .seg(seg), .dp(dp)
  );

  logic [0:6] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference model: m_t counts cycles since scanning started; slot/digit follow by division.
  bit          m_run, m_tick, m_pfull;
  int          m_t;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_actdp, m_penddp;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpv;
    logic [0:6]  s [4];
    logic [3:0]  edp;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired waiting for DUT event", name);
  endtask

  task automatic model_reset();
    m_run = 0; m_tick = 0; m_pfull = 0; m_t = 0;
    m_act = '0; m_pend = '0; m_actdp = '0; m_penddp = '0;
  endtask

  task automatic model_edge();
    bit acc, xfer, tick;
    acc  = wr_valid && !m_pfull;
    xfer = m_pfull && (!m_run || m_tick);
    tick = m_run && enable && ((m_t + 1) % (4 * DC) == 0);
    if (!enable) m_run = 0;
    else if (!m_run) begin m_run = 1; m_t = 0; end
    else m_t++;
    if (xfer) begin m_act = m_pend; m_actdp = m_penddp; m_pfull = 0; end
    if (acc) begin m_pend = wr_data; m_penddp = wr_dp; m_pfull = 1; end
    m_tick = tick;
  endtask

  function automatic logic [0:6] exp_seg_digit(input int i);
    logic [3:0] nib;
    nib = m_act[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && (m_act >> (4 * i)) == 16'h0) return 7'b1111111;
`endif
    return hex_tab[nib];
  endfunction

  task automatic compare_all();
    logic [0:3] ean;
    logic [0:6] eseg;
    logic       edp;
    ean = 4'b1111; eseg = 7'b1111111; edp = 1'b1;
    if (m_run && (m_t % DC) >= BC) begin
      int i;
      i = (m_t / DC) % 4;
      ean[i] = 1'b0;
      eseg   = exp_seg_digit(i);
      edp    = ~m_actdp[i];
    end
    check("an", an, ean);
    check("seg", seg, eseg);
    check("dp", dp, edp);
    check("frame_tick", frame_tick, m_tick);
    check("wr_ready", wr_ready, !m_pfull);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_vec(input int k, input logic [15:0] d, input logic [3:0] p,
                         input logic [0:6] s0, input logic [0:6] s1, input logic [0:6] s2,
                         input logic [0:6] s3, input logic [3:0] e);
    vt[k].data = d; vt[k].dpv = p; vt[k].edp = e;
    vt[k].s[0] = s0; vt[k].s[1] = s1; vt[k].s[2] = s2; vt[k].s[3] = s3;
  endtask

  initial begin
    bit prev_tick, seen;
    int first_tick;

    set_vec(0, 16'h3210, 4'b0001, 7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 4'b1110);
    set_vec(1, 16'h7654, 4'b0010, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 4'b1101);
    set_vec(2, 16'hBA98, 4'b0100, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 4'b1011);
    set_vec(3, 16'hFEDC, 4'b1000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000, 4'b0111);
    set_vec(4, 16'h12AF, 4'b0100, 7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111, 4'b1011);

    rst_n = 1'b0; enable = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_dp = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running scan with the reset word; measure frame_tick spacing.
    enable = 1'b1;
    first_tick = -1;
    seen = 0;
    for (int k = 0; k < 80 && !seen; k++) begin
      cyc();
      if (frame_tick) begin
        if (first_tick < 0) first_tick = k;
        else begin seen = 1; check("tick_period", k - first_tick, 32); end
      end
    end
    if (!seen) timeout("tick_period");

    // Mid-frame write, then a second write held off until after the next frame_tick.
    repeat (5) cyc();
    wr_valid = 1'b1; wr_data = 16'h12AF; wr_dp = 4'b0100;
    cyc();
    wr_data = 16'hC3D4; wr_dp = 4'b0001;
    check("b2b_held", wr_ready, 1'b0);
    seen = 0;
    for (int k = 0; k < 80 && !seen; k++) begin
      prev_tick = frame_tick;
      cyc();
      if (wr_ready) begin seen = 1; check("b2b_ready_after_tick", prev_tick, 1'b1); end
    end
    if (!seen) timeout("b2b_ready");
    cyc();
    wr_valid = 1'b0;
    check("b2b_second_taken", wr_ready, 1'b0);

    // Write on the exact frame_tick cycle with pending empty lands one frame later.
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      cyc();
      if (frame_tick && wr_ready) seen = 1;
    end
    if (!seen) timeout("tick_write_wait");
    wr_valid = 1'b1; wr_data = 16'h0009; wr_dp = 4'b0000;
    cyc();
    wr_valid = 1'b0;
    check("tickwr_pending", wr_ready, 1'b0);
    repeat (4) cyc();
    check("tickwr_not_current", seg, 7'b1001100);
    seen = 0;
    for (int k = 0; k < 80 && !seen; k++) begin
      cyc();
      if (frame_tick) seen = 1;
    end
    if (!seen) timeout("tickwr_next");
    repeat (5) cyc();
    check("tickwr_next_frame", seg, 7'b0000100);

    // Disable mid-DRIVE: dark next cycle, pending applied in IDLE, re-enable starts on digit 0.
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc();
      if (an != 4'b1111) seen = 1;
    end
    if (!seen) timeout("drive_wait");
    wr_valid = 1'b1; wr_data = 16'h0F00; wr_dp = 4'b0001;
    cyc();
    wr_valid = 1'b0; enable = 1'b0;
    cyc();
    check("dis_an_dark", an, 4'b1111);
    check("dis_seg_dark", seg, 7'b1111111);
    repeat (3) cyc();
    check("idle_xfer_ready", wr_ready, 1'b1);
    enable = 1'b1;
    repeat (2) cyc();
    check("reen_blank", an, 4'b1111);
    cyc();
    check("reen_digit0", an, 4'b0111);
    check("reen_seg", seg, 7'b0000001);
    check("reen_dp", dp, 1'b0);

    // Decode vectors loaded while idle, checked at the last cycle of each digit slot.
    for (int v = 0; v < 5; v++) begin
      enable = 1'b0;
      repeat (2) cyc();
      wr_valid = 1'b1; wr_data = vt[v].data; wr_dp = vt[v].dpv;
      cyc();
      wr_valid = 1'b0;
      repeat (2) cyc();
      enable = 1'b1;
      for (int k = 0; k < 4 * DC + 1; k++) begin
        cyc();
        if (m_run && (m_t % DC) == DC - 1) begin
          int i;
          i = (m_t / DC) % 4;
          check("vec_seg", seg, vt[v].s[i]);
          check("vec_dp", dp, vt[v].edp[i]);
        end
      end
    end

    // Randomised traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      enable   = ($urandom_range(0, 99) < 97);
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_data  = 16'($urandom);
      wr_dp    = 4'($urandom);
      cyc();
    end

    // Asynchronous reset mid-slot.
    enable = 1'b1; wr_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc();
      if (an != 4'b1111) seen = 1;
    end
    if (!seen) timeout("rst_drive_wait");
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_dp", dp, 1'b1);
    check("rst_ready", wr_ready, 1'b1);
    check("rst_tick", frame_tick, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
